uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Frame-level scheduler that shares the debug unit's single UART byte transmitter among several requesters (ping reply, signal dump, breakpoint report). It arbitrates round-robin and latches the winning frame: an opcode byte plus up to `PAYLOAD_BYTES` payload bytes. It then sequences the frame byte by byte through the transmitter's start/done handshake, and sits between the debug core logic and the bit-level UART TX.

## Interface
- `NUM_REQ`, 3, number of requesters
- `PAYLOAD_BYTES`, 8, maximum payload bytes per frame (payload width = 8·`PAYLOAD_BYTES`)
- `LEN_WIDTH`, 4, width of each length field; must be at least clog2(`PAYLOAD_BYTES`+1)
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `req`  in  `NUM_REQ`  frame request per requester, level, held until `grant`
- `req_opcode`  in  8·`NUM_REQ`  opcode byte, requester i at bits [8i+:8]
- `req_payload`  in  8·`PAYLOAD_BYTES`·`NUM_REQ`  payload, requester i at [i·8·`PAYLOAD_BYTES`+:8·`PAYLOAD_BYTES`], byte 0 = LSB
- `req_len`  in  `LEN_WIDTH`·`NUM_REQ`  payload byte count
- `grant`  out  `NUM_REQ`  one-hot, one-cycle pulse when the frame is latched
- `done`  out  `NUM_REQ`  one-hot, one-cycle pulse when the frame's last byte completes
- `busy`  out  1  high from grant until done
- `tx_byte`  out  8  byte to the transmitter
- `tx_start`  out  1  one-cycle start pulse to the transmitter
- `tx_busy`  in  1  transmitter not idle
- `tx_done`  in  1  one-cycle pulse after the transmitter's stop bit

## Operation
- States: IDLE, LOAD, WAIT.
- **IDLE:**
  - If `|req`, the round-robin pick is the first asserted requester searching from `last+1` (mod `NUM_REQ`).
  - Register `grant`, opcode, payload and len; `byte_idx`←0; `last`←pick; go to LOAD.
- **LOAD:**
  - When `!tx_busy`: drive `tx_byte` with the current byte and pulse `tx_start`; go to WAIT.
  - Otherwise stay in LOAD with `tx_start` low.
  - Byte order: opcode, then payload bytes 0..len-1.
- **WAIT:**
  - Hold `tx_byte` stable.
  - On `tx_done` with bytes remaining: increment `byte_idx` and go to LOAD.
  - On `tx_done` after the last byte: pulse `done[last]` and go to IDLE.
- **Length rules:**
  - len is clamped to `PAYLOAD_BYTES` at latch time.
  - len=0 sends the opcode only.
- **Request rules:**
  - `req` dropped before grant is never sent.
  - `req` held after grant is treated as a new frame request.
  - `req` inputs other than the latched frame are ignored while busy.
- **Reset:**
  - `rst` mid-frame aborts immediately, with no partial-frame completion and no `done`.
  - Reset values: `grant`=0, `done`=0, `busy`=0, `tx_start`=0, `tx_byte`=8'h00, state IDLE, `last`=`NUM_REQ`-1 (requester 0 wins first).
- `tx_done` outside WAIT is ignored.

## Timing
- `req` sampled high in IDLE at edge k → `grant`/`busy` high after edge k.
- `tx_start` with opcode after edge k+1 if `tx_busy` is low.
- Inter-byte gap: `tx_start` one cycle after each `tx_done`, when `tx_busy` is low.
- `done` pulses one cycle after the final `tx_done`; `busy` falls in the same cycle.
- New arbitration can occur at the edge following `done`. The same requester is therefore never back-to-back while others are pending.
- `tx_start` is never high for two consecutive cycles.

## Configuration
- `TX_SCHED_CHECKSUM_EN`:
  - When defined, one extra byte follows the last payload byte.
  - That byte is the XOR of the opcode and all sent (post-clamp) payload bytes.
  - `done` follows the checksum byte's `tx_done`.
- When undefined, frames end at the last payload byte and no checksum logic is built.

## Structure
- Shared package `debug_pkg`:
  - opcode constants OP_SIGNAL=8'h01, OP_OK=8'h02, OP_PING=8'h03, OP_PAUSE=8'h04, OP_RESUME=8'h05, OP_NEXT=8'h06, OP_PROGRAM=8'h07
  - scheduler state encoding
- One sub-module `round_robin_arbiter`:
  - parameter `NUM_REQ`; inputs `req`, `last`; output one-hot `pick`
  - combinational, with no internal state
- The scheduler owns `last`, the frame latches, the byte counter and the FSM.

## Test plan
- **Opcode-only frame.** `req[0]`, opcode 8'h02, len 0 → one `tx_start` with `tx_byte`=8'h02, then `done[0]` one cycle after `tx_done`. With the checksum enabled, a second byte 8'h02 is sent before `done`.
- **Full payload.** `req[1]`, opcode 8'h01, payload 64'h0000_0040_0000_0010, len 8 → bytes 01,10,00,00,00,40,00,00,00 in order.
- **Round robin.** All three `req` held continuously from reset → grant order 0,1,2,0; every `grant` follows the previous `done` by exactly one cycle.
- **Length clamp.** len=12 with `PAYLOAD_BYTES`=8 → exactly 8 payload bytes after the opcode.
- **Transmitter stall.** `tx_busy` held high for 100 cycles after grant → `tx_start` stays low, then pulses one cycle after `tx_busy` falls.
- **Reset mid-frame.** `rst` after the third `tx_done` of an 8-byte frame → all outputs go to reset values asynchronously, with no `done`. After release, with all `req` asserted, requester 0 is granted first and its frame restarts from the opcode.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared debug-unit definitions: protocol opcodes and the UART frame scheduler state encoding.
package debug_pkg;

    localparam logic [7:0] OP_SIGNAL  = 8'h01;
    localparam logic [7:0] OP_OK      = 8'h02;
    localparam logic [7:0] OP_PING    = 8'h03;
    localparam logic [7:0] OP_PAUSE   = 8'h04;
    localparam logic [7:0] OP_RESUME  = 8'h05;
    localparam logic [7:0] OP_NEXT    = 8'h06;
    localparam logic [7:0] OP_PROGRAM = 8'h07;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } sched_state_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin pick: first asserted request searching upward from last+1, wrapping.
// Latency: combinational. Backpressure: none, the caller decides when to consume the pick.
// No state: the caller owns and updates last.
module round_robin_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int LAST_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [LAST_W-1:0]  last,
    output logic [NUM_REQ-1:0] pick
);

    logic              found;
    logic [LAST_W-1:0] cand;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = LAST_W'((int'(last) + off) % NUM_REQ);
            if (!found && req[cand]) begin
                pick[cand] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Frame scheduler sharing one UART byte transmitter among NUM_REQ requesters; optional TX_SCHED_CHECKSUM_EN appends an XOR byte.
// Latency: grant one cycle after req in idle, opcode tx_start one cycle later, each next byte one cycle after tx_done.
// Backpressure: holds tx_start low while tx_busy is high; requesters stay pending (req held) until granted.
module uart_tx_scheduler
    import debug_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int PAYLOAD_BYTES = 8,
    parameter int LEN_WIDTH     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [8*NUM_REQ-1:0]                 req_opcode,
    input  logic [8*PAYLOAD_BYTES*NUM_REQ-1:0]   req_payload,
    input  logic [LEN_WIDTH*NUM_REQ-1:0]         req_len,
    output logic [NUM_REQ-1:0]                   grant,
    output logic [NUM_REQ-1:0]                   done,
    output logic                                 busy,
    output logic [7:0]                           tx_byte,
    output logic                                 tx_start,
    input  logic                                 tx_busy,
    input  logic                                 tx_done
);

    localparam int LW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDX_W = LEN_WIDTH + 1;
    localparam int PW    = 8 * PAYLOAD_BYTES;

    sched_state_t         state_q;
    logic [NUM_REQ-1:0]   grant_q, done_q;
    logic                 busy_q, tx_start_q;
    logic [7:0]           tx_byte_q;
    logic [LW-1:0]        last_q;
    logic [7:0]           opcode_q;
    logic [PW-1:0]        payload_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [IDX_W-1:0]     byte_idx_q;
`ifdef TX_SCHED_CHECKSUM_EN
    logic [7:0]           csum_q;
`endif

    logic [NUM_REQ-1:0]   pick;
    logic [LW-1:0]        pick_idx_d;
    logic [7:0]           opcode_d;
    logic [PW-1:0]        payload_d;
    logic [LEN_WIDTH-1:0] len_raw_d, len_d;
    logic [7:0]           cur_byte_d;
    logic [IDX_W-1:0]     last_idx_d;

    round_robin_arbiter #(.NUM_REQ(NUM_REQ), .LAST_W(LW)) u_arb (
        .req  (req),
        .last (last_q),
        .pick (pick)
    );

    always_comb begin
        pick_idx_d = '0;
        opcode_d   = '0;
        payload_d  = '0;
        len_raw_d  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx_d = LW'(i);
                opcode_d   = req_opcode[8*i +: 8];
                payload_d  = req_payload[PW*i +: PW];
                len_raw_d  = req_len[LEN_WIDTH*i +: LEN_WIDTH];
            end
        end
        len_d = (len_raw_d > LEN_WIDTH'(PAYLOAD_BYTES)) ? LEN_WIDTH'(PAYLOAD_BYTES) : len_raw_d;
    end

    // Byte 0 is the opcode, 1..len the payload; the checksum slot (len+1) overrides.
    always_comb begin
        cur_byte_d = opcode_q;
        for (int j = 0; j < PAYLOAD_BYTES; j++) begin
            if (byte_idx_q == IDX_W'(j + 1)) cur_byte_d = payload_q[8*j +: 8];
        end
        last_idx_d = IDX_W'(len_q);
`ifdef TX_SCHED_CHECKSUM_EN
        if (byte_idx_q == IDX_W'(len_q) + 1'b1) cur_byte_d = csum_q;
        last_idx_d = IDX_W'(len_q) + 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= 8'h00;
            last_q     <= LW'(NUM_REQ - 1);
            opcode_q   <= '0;
            payload_q  <= '0;
            len_q      <= '0;
            byte_idx_q <= '0;
`ifdef TX_SCHED_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            grant_q    <= '0;
            done_q     <= '0;
            tx_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        grant_q    <= pick;
                        last_q     <= pick_idx_d;
                        opcode_q   <= opcode_d;
                        payload_q  <= payload_d;
                        len_q      <= len_d;
                        byte_idx_q <= '0;
                        busy_q     <= 1'b1;
`ifdef TX_SCHED_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!tx_busy) begin
                        tx_byte_q  <= cur_byte_d;
                        tx_start_q <= 1'b1;
`ifdef TX_SCHED_CHECKSUM_EN
                        csum_q     <= csum_q ^ cur_byte_d;
`endif
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        if (byte_idx_q == last_idx_d) begin
                            done_q  <= NUM_REQ'(1) << last_q;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                            state_q    <= ST_LOAD;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign tx_byte  = tx_byte_q;
    assign tx_start = tx_start_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a simple byte-transmitter model; handles TX_SCHED_CHECKSUM_EN builds.
module tb_uart_tx_scheduler;

    localparam int NR = 3, PB = 8, LWID = 4, TX_CYC = 4;
`ifdef TX_SCHED_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NR-1:0]        req = '0;
    logic [8*NR-1:0]      req_opcode = '0;
    logic [8*PB*NR-1:0]   req_payload = '0;
    logic [LWID*NR-1:0]   req_len = '0;
    logic [NR-1:0]        grant, done;
    logic                 busy, tx_start, tx_busy;
    logic                 tx_done = 1'b0;
    logic [7:0]           tx_byte;
    logic                 model_busy = 1'b0, force_busy = 1'b0;

    assign tx_busy = model_busy | force_busy;

    uart_tx_scheduler #(.NUM_REQ(NR), .PAYLOAD_BYTES(PB), .LEN_WIDTH(LWID)) dut (
        .clk(clk), .rst(rst), .req(req), .req_opcode(req_opcode), .req_payload(req_payload),
        .req_len(req_len), .grant(grant), .done(done), .busy(busy), .tx_byte(tx_byte),
        .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, b2b = 0, tdone_cyc = 0, tdone_cnt = 0;
    logic prev_start = 1'b0;
    logic [7:0] seen[$];
    int seen_cyc[$], g_idx[$], g_cyc[$], d_cyc[$];
    logic [7:0] exp_b[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Observes DUT outputs just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (tx_start) begin
                if (prev_start) b2b++;
                seen.push_back(tx_byte);
                seen_cyc.push_back(cyc);
            end
            prev_start = tx_start;
            for (int i = 0; i < NR; i++) begin
                if (grant[i]) begin
                    g_idx.push_back(i);
                    g_cyc.push_back(cyc);
                end
            end
            if (|done) d_cyc.push_back(cyc);
        end
    end

    // Transmitter model: busy for TX_CYC cycles after a start, then a one-cycle done.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx_start) begin
                model_busy = 1'b1;
                repeat (TX_CYC) @(posedge clk);
                #1;
                tx_done    = 1'b1;
                model_busy = 1'b0;
                tdone_cyc  = cyc;
                tdone_cnt++;
                @(posedge clk);
                #1;
                tx_done = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input logic [7:0] op, input logic [63:0] pay, input logic [3:0] len);
        req_opcode[8*i +: 8]   = op;
        req_payload[64*i +: 64] = pay;
        req_len[4*i +: 4]      = len;
    endtask

    task automatic clear_logs();
        seen.delete(); seen_cyc.delete(); g_idx.delete(); g_cyc.delete(); d_cyc.delete(); exp_b.delete();
    endtask

    task automatic wait_grant(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (|grant) ok = 1'b1;
        end
        chk({tag, "_grant_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (|done) ok = 1'b1;
        end
        chk({tag, "_done_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic compare_seen(input string tag);
        chk({tag, "_count"}, 64'(seen.size()), 64'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < seen.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), 64'(seen[i]), 64'(exp_b[i]));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int c0, base, nd;
        bit ok;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tx_start", 64'(tx_start), 64'd0);
        chk("rst_tx_byte", 64'(tx_byte), 64'h00);
        rst = 1'b0;
        @(negedge clk);

        // Opcode-only frame
        clear_logs();
        set_req(0, 8'h02, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0);
        req = 3'b001;
        wait_grant("op_only");
        chk("op_only_grant", 64'(grant), 64'b001);
        chk("op_only_busy", 64'(busy), 64'd1);
        req = '0;
        wait_done("op_only");
        chk("op_only_done", 64'(done), 64'b001);
        chk("op_only_busy_low", 64'(busy), 64'd0);
        chk("op_only_done_lat", 64'(d_cyc[0] - tdone_cyc), 64'd1);
        if (seen_cyc.size() > 0) chk("op_only_start_lat", 64'(seen_cyc[0] - g_cyc[0]), 64'd1);
        exp_b = '{8'h02};
        if (CS == 1) exp_b.push_back(8'h02);
        compare_seen("op_only");

        // Full payload
        clear_logs();
        set_req(1, 8'h01, 64'h0000_0040_0000_0010, 4'd8);
        req = 3'b010;
        wait_grant("full");
        chk("full_grant", 64'(grant), 64'b010);
        req = '0;
        wait_done("full");
        chk("full_done", 64'(done), 64'b010);
        exp_b = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00};
        if (CS == 1) exp_b.push_back(8'h51);
        compare_seen("full");

        // Round robin from reset with all requests held
        pulse_reset();
        clear_logs();
        set_req(0, 8'hA0, 64'h0, 4'd0);
        set_req(1, 8'hA1, 64'h0, 4'd0);
        set_req(2, 8'hA2, 64'h0, 4'd0);
        req = 3'b111;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (g_idx.size() >= 4) req = '0;
            if (d_cyc.size() >= 4) ok = 1'b1;
        end
        req = '0;
        chk("rr_complete", 64'(ok), 64'd1);
        if (ok) begin
            chk("rr_g0", 64'(g_idx[0]), 64'd0);
            chk("rr_g1", 64'(g_idx[1]), 64'd1);
            chk("rr_g2", 64'(g_idx[2]), 64'd2);
            chk("rr_g3", 64'(g_idx[3]), 64'd0);
            for (int k = 1; k < 4; k++)
                chk($sformatf("rr_gap%0d", k), 64'(g_cyc[k] - d_cyc[k-1]), 64'd1);
        end
        repeat (2) @(negedge clk);

        // Length clamp
        clear_logs();
        set_req(2, 8'h07, 64'h8877_6655_4433_2211, 4'd12);
        req = 3'b100;
        wait_grant("clamp");
        chk("clamp_grant", 64'(grant), 64'b100);
        req = '0;
        wait_done("clamp");
        exp_b = '{8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        if (CS == 1) exp_b.push_back(8'h8F);
        compare_seen("clamp");

        // Transmitter stall
        clear_logs();
        force_busy = 1'b1;
        set_req(0, 8'h03, 64'h0, 4'd0);
        req = 3'b001;
        wait_grant("stall");
        req = '0;
        repeat (100) @(negedge clk);
        chk("stall_quiet", 64'(seen.size()), 64'd0);
        force_busy = 1'b0;
        c0 = cyc;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (seen.size() > 0) ok = 1'b1;
        end
        chk("stall_start_seen", 64'(ok), 64'd1);
        if (ok) chk("stall_release_lat", 64'(seen_cyc[0] - c0), 64'd1);
        wait_done("stall");

        // Reset mid-frame after the third tx_done
        clear_logs();
        set_req(1, 8'h04, 64'h1817_1615_1413_1211, 4'd8);
        req = 3'b010;
        wait_grant("midrst");
        req = '0;
        base = tdone_cnt;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (tdone_cnt - base >= 3) ok = 1'b1;
        end
        chk("midrst_third_done", 64'(ok), 64'd1);
        chk("midrst_pre_busy", 64'(busy), 64'd1);
        nd = d_cyc.size();
        rst = 1'b1;
        #1;
        chk("midrst_grant", 64'(grant), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_tx_start", 64'(tx_start), 64'd0);
        chk("midrst_tx_byte", 64'(tx_byte), 64'h00);
        set_req(0, 8'h55, 64'h0000_0000_0000_0066, 4'd1);
        set_req(1, 8'hB1, 64'h0, 4'd0);
        set_req(2, 8'hB2, 64'h0, 4'd0);
        req = 3'b111;
        repeat (8) @(negedge clk);
        chk("midrst_no_done", 64'(d_cyc.size() - nd), 64'd0);
        seen.delete(); seen_cyc.delete();
        rst = 1'b0;
        wait_grant("restart");
        chk("restart_grant", 64'(grant), 64'b001);
        req = '0;
        wait_done("restart");
        chk("restart_done", 64'(done), 64'b001);
        exp_b = '{8'h55, 8'h66};
        if (CS == 1) exp_b.push_back(8'h33);
        compare_seen("restart");

        chk("start_never_b2b", 64'(b2b), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
